instruction_memory_loadable: RTL
================================

Name: instruction_memory_loadable

Overview:
Parametrised, synchronous-read instruction memory for the MIPS core, replacing the fixed combinational program ROM. Program images are written at run time through a load port (bootloader/UART side). The core fetches through a request/valid handshake with one-cycle latency. After reset, or on request, a built-in init sequencer fills the array with a NOP word, and misaligned or out-of-range fetches are flagged as faults.

Parameters:
ADDR_WIDTH, 32, width of the byte fetch address.
DEPTH_LOG2, 8, log2 of the number of words (default 256 words, 1 KiB).
DATA_WIDTH, 32, instruction word width.
NOP_WORD, 32'h00000000, fill value for init and the value returned on a faulting fetch.

Ports:
clk  in  1  rising-edge clock.
reset_n  in  1  asynchronous, active-low reset.
clear_req  in  1  one-cycle pulse; restarts the init fill from IDLE.
fetch_req  in  1  fetch request, sampled at clk edge.
fetch_addr  in  ADDR_WIDTH  byte address of the fetch.
fetch_valid  out  1  one-cycle pulse; fetch_instr/fetch_fault are valid.
fetch_instr  out  DATA_WIDTH  fetched word.
fetch_fault  out  1  fetch was misaligned or out of range.
load_valid  in  1  load write strobe.
load_addr  in  DEPTH_LOG2  word index to write.
load_data  in  DATA_WIDTH  word to write.
load_ready  out  1  a load is accepted this cycle.
busy  out  1  init fill in progress.

Behaviour:
- Reset (reset_n=0, asynchronous) forces these values:
  - state=INIT, fill counter=0, busy=1, load_ready=0.
  - fetch_valid=0, fetch_fault=0, fetch_instr=NOP_WORD.
  - Array contents are not reset directly; the INIT fill overwrites them.
- The state machine has two states, INIT and IDLE.
- INIT state:
  - Each cycle writes NOP_WORD to mem[counter], then increments the counter.
  - After writing word 2^DEPTH_LOG2-1, goes to IDLE, so the fill takes exactly 2^DEPTH_LOG2 cycles after reset release.
  - busy=1 and load_ready=0 throughout.
  - fetch_req and load_valid are ignored; fetch_valid stays 0 and no fault is raised.
- IDLE state:
  - busy=0 and load_ready=1 (combinational from state).
  - clear_req=1 goes to INIT with counter=0 on the next edge; a load presented in that same cycle is still written.
  - clear_req while already in INIT is ignored; the fill does not restart.
- Load: when load_valid and load_ready are both 1 at a clk edge, mem[load_addr] is written with load_data.
- Fetch timing: fetch_req=1 in IDLE at edge N gives fetch_valid=1 during cycle N+1, with a registered result.
  - Back-to-back requests give back-to-back valid pulses, with no bubbles.
  - fetch_valid=0 in any cycle with no request at the previous edge.
- Fetch result:
  - Word index is fetch_addr[DEPTH_LOG2+1:2].
  - Fault when fetch_addr[1:0]!=0, or when any bit of fetch_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] is 1.
  - On a fault: fetch_instr=NOP_WORD and fetch_fault=1.
  - Otherwise: fetch_instr=mem[index] and fetch_fault=0.
- Output hold: fetch_instr and fetch_fault keep their last values while fetch_valid=0.
- Same-cycle load and fetch to the same word: the fetch returns the old contents (read-before-write); the next fetch returns the new data.
- Reset asserted mid-INIT or mid-fetch: immediate return to the reset values; the fill restarts from word 0, and any pending fetch result is dropped (fetch_valid=0).
- Width rule: DEPTH_LOG2+2 <= ADDR_WIDTH is required. When they are equal, only the misalignment check applies.

Test Plan:
1. Release reset with DEPTH_LOG2=8 -> busy=1 for exactly 256 cycles, then busy=0 and load_ready=1; a fetch_req held during INIT gives no fetch_valid.
2. Load word 3 = 32'h201c0000, then fetch 0x0000000C -> next cycle fetch_valid=1, fetch_instr=32'h201c0000, fetch_fault=0.
3. Fetch 0x0000000D -> fault=1, instr=NOP_WORD. Fetch 0x00000400 -> fault=1, instr=NOP_WORD. Fetch 0x000003FC of an unloaded word -> fault=0, instr=NOP_WORD.
4. Start with word 5 = 32'h08000003.
   - Same cycle: load word 5 = 32'h0800002e and fetch 0x14 -> returns 32'h08000003.
   - Next fetch of 0x14 -> returns 32'h0800002e.
   - Back-to-back fetches of 0x0C, 0x10, 0x14 -> three consecutive valid pulses with the matching words.
5. Load words 0..3, pulse clear_req -> busy=1 for 256 cycles; afterwards fetches of 0x0, 0x4, 0x8 and 0xC all return NOP_WORD.
6. Assert reset_n=0 at fill count 100, release it -> busy lasts a full 256 cycles from the release; an in-flight fetch gives no valid pulse.

Source files
------------

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: synchronous one-cycle fetch, run-time load port,
// and a NOP fill sequencer that runs after reset or on clear_req.
module instruction_memory_loadable #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG2 = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  fetch_fault,
  input  logic                  load_valid,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  busy
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [Depth];

  logic                    we;
  logic [DEPTH_LOG2-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;

  logic                    fetch_fire;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    fault;
  logic [DEPTH_LOG2-1:0]   ridx;

  logic                    valid_q;
  logic                    fault_q;
  logic [DATA_WIDTH-1:0]   instr_q;

  // Sequencer and shared write port: fill owns the port in StInit, loads own it in StIdle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we         = 1'b0;
    waddr      = load_addr;
    wdata      = load_data;
    busy       = 1'b0;
    load_ready = 1'b0;
    unique case (state_q)
      StInit: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = cnt_q;
        wdata = NOP_WORD;
        cnt_d = cnt_q + DEPTH_LOG2'(1);
        if (cnt_q == '1) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        load_ready = 1'b1;
        we         = load_valid;
        if (clear_req) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  assign fetch_fire = fetch_req && (state_q == StIdle);
  assign misaligned = |fetch_addr[1:0];
  assign ridx       = fetch_addr[DEPTH_LOG2+1:2];

  // With a full-width word index there are no upper bits to range-check.
  if (DEPTH_LOG2 + 2 < ADDR_WIDTH) begin : g_range
    assign out_of_range = |fetch_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  assign fault = misaligned || out_of_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= NOP_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= fetch_fire;
      if (fetch_fire) begin
        // Read sees pre-edge contents, so a same-cycle load to this word is not visible yet.
        instr_q <= fault ? NOP_WORD : mem[ridx];
        fault_q <= fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_instr = instr_q;
  assign fetch_fault = fault_q;

endmodule
